// File: rtl/led_color_ctrl.sv
// Status-driven RGB colour source: classifies temperature with hysteresis, fades three 8-bit
// levels toward a per-status target on a prescaled tick, and blinks red while over-temperature.
module led_color_ctrl #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned BLINK_TICKS = 128,
  parameter int unsigned STEP        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] temp,
  input  logic        temp_vld,
  input  logic [11:0] lo_thr,
  input  logic [11:0] hi_thr,
  input  logic [7:0]  hyst,
  output logic [7:0]  lvl_r,
  output logic [7:0]  lvl_g,
  output logic [7:0]  lvl_b,
  output logic [1:0]  state,
  output logic        upd
);

  localparam int unsigned PresW  = $clog2(TICK_DIV);
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PresW-1:0]  PresLast  = PresW'(TICK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);
  localparam logic [8:0]        Step9     = 9'(STEP);
  localparam logic [7:0]        Step8     = 8'(STEP);

  localparam logic [7:0] LvlOff  = 8'h00;
  localparam logic [7:0] LvlFull = 8'hFF;
  localparam logic [7:0] LvlDim  = 8'h20;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StOk   = 2'd1,
    StLow  = 2'd2,
    StHigh = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Fade tick prescaler
  // ---------------------------------------------------------------------------------------------
  logic [PresW-1:0] pres_q, pres_d;
  logic             tick;

  always_comb begin
    tick   = (pres_q == PresLast);
    pres_d = tick ? '0 : pres_q + PresW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Temperature classification
  // ---------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [12:0] temp_ext, lo_ext, hi_ext, lo_plus_hyst, temp_plus_hyst;
  logic        above_hi, below_lo, clear_of_low, clear_of_high;

  // 13-bit arithmetic keeps threshold + hysteresis sums from wrapping.
  always_comb begin
    temp_ext       = {1'b0, temp};
    lo_ext         = {1'b0, lo_thr};
    hi_ext         = {1'b0, hi_thr};
    lo_plus_hyst   = lo_ext + {5'b0, hyst};
    temp_plus_hyst = temp_ext + {5'b0, hyst};
    above_hi       = (temp_ext > hi_ext);
    below_lo       = (temp_ext < lo_ext);
    clear_of_low   = (temp_ext >= lo_plus_hyst);
    clear_of_high  = (temp_plus_hyst <= hi_ext);
  end

  always_comb begin
    state_d = state_q;
    if (temp_vld) begin
      unique case (state_q)
        StInit, StOk: begin
          if (above_hi) begin
            state_d = StHigh;
          end else if (below_lo) begin
            state_d = StLow;
          end else begin
            state_d = StOk;
          end
        end
        StLow: begin
          if (above_hi) begin
            state_d = StHigh;
          end else if (clear_of_low) begin
            state_d = StOk;
          end
        end
        StHigh: begin
          if (below_lo) begin
            state_d = StLow;
          end else if (clear_of_high) begin
            state_d = StOk;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Over-temperature blink
  // ---------------------------------------------------------------------------------------------
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              enter_high;

  always_comb begin
    enter_high  = (state_d == StHigh) && (state_q != StHigh);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (enter_high) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick && (state_q == StHigh)) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Colour target, from the pre-edge state so a coincident classification waits one tick
  // ---------------------------------------------------------------------------------------------
  logic [7:0] tgt_r, tgt_g, tgt_b;

  always_comb begin
    tgt_r = LvlOff;
    tgt_g = LvlOff;
    tgt_b = LvlOff;
    unique case (state_q)
      StInit: begin
        tgt_r = LvlDim;
        tgt_g = LvlDim;
        tgt_b = LvlDim;
      end
      StOk:    tgt_g = LvlFull;
      StLow:   tgt_b = LvlFull;
      StHigh:  tgt_r = phase_q ? LvlFull : LvlOff;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Per-channel fade
  // ---------------------------------------------------------------------------------------------
  // Snaps to the target when within one step, so the level never overshoots or wraps.
  function automatic logic [7:0] fade_step(input logic [7:0] lvl, input logic [7:0] tgt);
    logic [8:0] diff;
    if (tgt >= lvl) begin
      diff      = {1'b0, tgt} - {1'b0, lvl};
      fade_step = (diff <= Step9) ? tgt : lvl + Step8;
    end else begin
      diff      = {1'b0, lvl} - {1'b0, tgt};
      fade_step = (diff <= Step9) ? tgt : lvl - Step8;
    end
  endfunction

  logic [7:0] lvl_r_q, lvl_r_d;
  logic [7:0] lvl_g_q, lvl_g_d;
  logic [7:0] lvl_b_q, lvl_b_d;
  logic       upd_q, upd_d;

  always_comb begin
    lvl_r_d = lvl_r_q;
    lvl_g_d = lvl_g_q;
    lvl_b_d = lvl_b_q;
    if (tick) begin
      lvl_r_d = fade_step(lvl_r_q, tgt_r);
      lvl_g_d = fade_step(lvl_g_q, tgt_g);
      lvl_b_d = fade_step(lvl_b_q, tgt_b);
    end
    upd_d = tick && ((lvl_r_d != lvl_r_q) || (lvl_g_d != lvl_g_q) || (lvl_b_d != lvl_b_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_r_q <= LvlOff;
      lvl_g_q <= LvlOff;
      lvl_b_q <= LvlOff;
      upd_q   <= 1'b0;
    end else begin
      lvl_r_q <= lvl_r_d;
      lvl_g_q <= lvl_g_d;
      lvl_b_q <= lvl_b_d;
      upd_q   <= upd_d;
    end
  end

  assign lvl_r = lvl_r_q;
  assign lvl_g = lvl_g_q;
  assign lvl_b = lvl_b_q;
  assign state = state_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_led_color_ctrl.sv
// Scoreboard bench for led_color_ctrl: a cycle-count/abstract reference model queues every
// expected level update; an independent monitor checks each upd pulse against the queue.
module tb_led_color_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned BT = 8;
  localparam int unsigned ST = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] temp = 12'd0;
  logic        temp_vld = 1'b0;
  logic [11:0] lo_thr = 12'd400;
  logic [11:0] hi_thr = 12'd600;
  logic [7:0]  hyst = 8'd10;
  logic [7:0]  lvl_r, lvl_g, lvl_b;
  logic [1:0]  state;
  logic        upd;

  led_color_ctrl #(
    .TICK_DIV   (TD),
    .BLINK_TICKS(BT),
    .STEP       (ST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .temp    (temp),
    .temp_vld(temp_vld),
    .lo_thr  (lo_thr),
    .hi_thr  (hi_thr),
    .hyst    (hyst),
    .lvl_r   (lvl_r),
    .lvl_g   (lvl_g),
    .lvl_b   (lvl_b),
    .state   (state),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: edges since reset release, ticks spent in HIGH, plain integer levels.
  int m_state;
  int m_edge;
  int m_high;
  int m_lvl[3];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int approach(input int l, input int t);
    int d;
    d = (t > l) ? t - l : l - t;
    if (d <= ST) return t;
    return (t > l) ? l + ST : l - ST;
  endfunction

  function automatic int classify(input int pre, input int t, input int lo, input int hi,
                                  input int hy);
    case (pre)
      0, 1: begin
        if (t > hi) return 3;
        if (t < lo) return 2;
        return 1;
      end
      2: begin
        if (t > hi) return 3;
        if (t >= lo + hy) return 1;
        return 2;
      end
      default: begin
        if (t < lo) return 2;
        if (t + hy <= hi) return 1;
        return 3;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_edge  = 0;
    m_high  = 0;
    for (int i = 0; i < 3; i++) m_lvl[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int   pre;
    int   tgt[3];
    int   nl;
    bit   tick;
    bit   phase;
    bit   chg;
    exp_t e;
    m_edge++;
    tick  = (m_edge % TD) == 0;
    pre   = m_state;
    phase = ((m_high / BT) % 2) == 0;
    case (pre)
      0:       begin tgt[0] = 32;  tgt[1] = 32;  tgt[2] = 32;  end
      1:       begin tgt[0] = 0;   tgt[1] = 255; tgt[2] = 0;   end
      2:       begin tgt[0] = 0;   tgt[1] = 0;   tgt[2] = 255; end
      default: begin tgt[0] = phase ? 255 : 0; tgt[1] = 0; tgt[2] = 0; end
    endcase
    chg = 1'b0;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        nl = approach(m_lvl[i], tgt[i]);
        if (nl != m_lvl[i]) chg = 1'b1;
        m_lvl[i] = nl;
      end
      if (pre == 3) m_high++;
    end
    if (temp_vld) begin
      m_state = classify(pre, int'(temp), int'(lo_thr), int'(hi_thr), int'(hyst));
      if (m_state == 3 && pre != 3) m_high = 0;
    end
    if (chg) begin
      e.r  = m_lvl[0];
      e.g  = m_lvl[1];
      e.b  = m_lvl[2];
      e.st = m_state;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [11:0] t);
    temp_vld = v;
    temp     = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    temp_vld = 1'b0;
    if (v) check("state_after_vld", int'(state), m_state);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, temp);
  endtask

  task automatic sync_reset_cycle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every upd pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && upd) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL upd_unexpected: upd=1 lvl=%02h/%02h/%02h, expected no update (t=%0t)",
                   lvl_r, lvl_g, lvl_b, $time);
        end else begin
          e = exp_q.pop_front();
          check("upd_lvl_r", int'(lvl_r), e.r);
          check("upd_lvl_g", int'(lvl_g), e.g);
          check("upd_lvl_b", int'(lvl_b), e.b);
          check("upd_state", int'(state), e.st);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_lvl_r", int'(lvl_r), 0);
    check("reset_lvl_g", int'(lvl_g), 0);
    check("reset_state", int'(state), 0);
    check("reset_upd", int'(upd), 0);
    rst_n = 1'b1;

    // Power-up dim white
    idle(12);
    check("init_lvl_r", int'(lvl_r), 32);
    check("init_lvl_b", int'(lvl_b), 32);
    check("init_state", int'(state), 0);

    // OK: green full, others off
    step(1'b1, 12'd500);
    check("ok_state", int'(state), 1);
    idle(60);
    check("ok_lvl_g", int'(lvl_g), 255);
    check("ok_lvl_r", int'(lvl_r), 0);

    // Hysteresis around the low threshold
    step(1'b1, 12'd399);
    check("low_enter", int'(state), 2);
    idle(12);
    step(1'b1, 12'd405);
    check("low_hold", int'(state), 2);
    idle(5);
    step(1'b1, 12'd410);
    check("low_exit", int'(state), 1);
    idle(8);

    // Over-temperature blink and hysteresis around the high threshold
    step(1'b1, 12'd601);
    check("high_enter", int'(state), 3);
    idle(100);
    step(1'b1, 12'd591);
    check("high_hold", int'(state), 3);
    idle(3);
    step(1'b1, 12'd590);
    check("high_exit", int'(state), 1);
    step(1'b1, 12'd601);
    idle(7);
    step(1'b1, 12'd399);
    check("high_to_low", int'(state), 2);

    // Classification coinciding with a tick edge
    while ((m_edge % TD) != TD - 1) idle(1);
    step(1'b1, 12'd601);
    idle(9);
    while ((m_edge % TD) != TD - 1) idle(1);
    step(1'b1, 12'd500);
    idle(6);

    // Asynchronous reset mid-ramp
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lvl_g", int'(lvl_g), 0);
    check("async_rst_lvl_r", int'(lvl_r), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_upd", int'(upd), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Inverted thresholds and extreme hysteresis
    lo_thr = 12'd700;
    hi_thr = 12'd600;
    step(1'b1, 12'd650);
    check("misconfig_high", int'(state), 3);
    idle(6);
    lo_thr = 12'd400;
    hyst   = 8'd255;
    step(1'b1, 12'd4095);
    check("max_temp_hold", int'(state), 3);
    idle(6);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 8) begin
        lo_thr = 12'($urandom_range(0, 4095));
        hi_thr = 12'($urandom_range(0, 4095));
        hyst   = 8'($urandom_range(0, 255));
      end else if (r < 14) begin
        lo_thr = 12'd400;
        hi_thr = 12'd600;
        hyst   = 8'd10;
      end else if (r < 16) begin
        sync_reset_cycle();
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       step(1'b1, 12'(int'(lo_thr) + int'($urandom_range(0, 40)) - 20));
          1:       step(1'b1, 12'(int'(hi_thr) + int'($urandom_range(0, 40)) - 20));
          2:       step(1'b1, 12'($urandom_range(380, 620)));
          default: step(1'b1, 12'($urandom_range(0, 4095)));
        endcase
      end else begin
        idle(1);
      end
    end

    idle(4);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_color_ctrl.md
Name: led_color_ctrl

Overview:
Upstream colour source for the RGB LED driver. It classifies tank temperature readings against programmable low/high thresholds with hysteresis, and picks a target colour per status. It fades three 8-bit channel levels toward that target at a fixed tick rate and blinks red on over-temperature. The lvl_r/lvl_g/lvl_b outputs feed the driver's PWM stage directly.

Parameters:
TICK_DIV, 50000, clk cycles per fade tick (>=2)
BLINK_TICKS, 128, fade ticks per blink half-period in HIGH (>=1)
STEP, 8, level change per tick per channel (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
temp  in  12  unsigned temperature reading
temp_vld  in  1  1-cycle strobe; temp valid this cycle
lo_thr  in  12  low threshold, quasi-static
hi_thr  in  12  high threshold, quasi-static
hyst  in  8  hysteresis, in temp LSBs
lvl_r  out  8  red level, 0x00 off .. 0xFF full
lvl_g  out  8  green level
lvl_b  out  8  blue level
state  out  2  status: 0 INIT, 1 OK, 2 LOW, 3 HIGH
upd  out  1  high for the one cycle in which new levels first appear

Behaviour:
- Reset, async on rst_n low:
  - lvl_r/g/b = 0x00, state = INIT, upd = 0.
  - Prescaler = 0, blink counter = 0, blink phase = 1.
  - Reset mid-fade clears everything immediately; no partial step completes.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted internally for the cycle where count == TICK_DIV-1.
  - The first tick after reset occurs on clock edge TICK_DIV.
- Classification happens only on temp_vld. The state register updates on the same edge that samples temp_vld. All compares are 13-bit so nothing overflows.
  - INIT: temp > hi_thr -> HIGH; else temp < lo_thr -> LOW; else OK.
  - OK: temp > hi_thr -> HIGH; else temp < lo_thr -> LOW.
  - LOW: temp > hi_thr -> HIGH; else temp >= lo_thr + hyst -> OK; else stay.
  - HIGH: temp < lo_thr -> LOW; else temp + hyst <= hi_thr -> OK; else stay.
  - The HIGH check has priority, so a misconfigured lo_thr > hi_thr resolves to HIGH.
  - temp_vld low: state holds.
- Targets (r, g, b):
  - INIT: 0x20, 0x20, 0x20.
  - OK: 0x00, 0xFF, 0x00.
  - LOW: 0x00, 0x00, 0xFF.
  - HIGH: (phase ? 0xFF : 0x00), 0x00, 0x00.
- Blink:
  - Counter and phase run only in HIGH.
  - On entry to HIGH from any other state: counter = 0, phase = 1.
  - Each tick in HIGH increments the counter. At BLINK_TICKS-1 the counter wraps to 0 and phase toggles.
- Fade, on tick edges only. Per channel:
  - If |target - lvl| <= STEP: lvl = target.
  - Else lvl moves by STEP toward target.
  - Never overshoots; no 8-bit wrap.
- Simultaneous temp_vld and tick: the fade step uses the target of the pre-edge state. The new state's target applies from the next tick.
- upd:
  - Registered. Set on a tick edge if any level changed at that edge; otherwise 0.
  - Coincides with the first cycle the new levels are visible.
  - Stays 0 once all channels equal their targets, except for blink toggles.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
All scenarios use TICK_DIV=4, BLINK_TICKS=8, STEP=16; thresholds lo=400, hi=600, hyst=10 unless stated.
1. Reset release, no temp_vld -> state=0; levels 0x10 after the edge-4 tick, 0x20 after the edge-8 tick; upd pulses exactly twice, then stays 0.
2. From scenario 1, temp=500 vld -> state=1 next edge. lvl_g reaches 0xF0 after 13 ticks and 0xFF on the 14th. lvl_r and lvl_b reach 0x00 after 2 ticks.
3. Hysteresis, from OK:
   - temp=399 -> LOW.
   - temp=405 -> stays LOW.
   - temp=410 -> OK.
   - lvl_b climbs in steps of 16 while in LOW.
4. HIGH and blink:
   - temp=601 -> state=3; red ramps to 0xFF.
   - After 8 ticks phase=0 and red ramps down; the period repeats.
   - temp=591 -> stays HIGH; temp=590 -> OK.
   - temp=399 while in HIGH -> LOW directly.
5. Simultaneous events and mid-operation reset:
   - temp_vld on a tick cycle -> that edge steps toward the old target; the following tick steps toward the new one.
   - rst_n low mid-ramp -> levels 0x00 and state=0 asynchronously, before the next clk edge.
6. Misconfig lo=700, hi=600, temp=650 -> HIGH. Also temp=4095 with hyst=255 from HIGH -> stays HIGH, with no overflow false exit.
